dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the single data-memory port between the pipeline MEM stage and an external loader/debug requester. The block sits between the EX/MEM registers and `data_memory`. Pipeline accesses have priority. An optional fairness counter guarantees that the external requester eventually gets the port, by stalling the pipeline for exactly one cycle. External read data returns through a registered valid/data pair.

## Interface
Parameters:
- `ADDR_W`, 12, data-memory address width.
- `DATA_W`, 32, data width.
- `STARVE_LIMIT`, 4, consecutive pipeline wins tolerated while an external request waits; legal range 1..15.

Ports:
- `clock` in 1: rising-edge clock; single clock domain.
- `reset_n` in 1: synchronous, active-low reset.
- `pipe_rd` in 1: MEM-stage read request (lw).
- `pipe_wr` in 1: MEM-stage write request (sw); never asserted together with `pipe_rd`.
- `pipe_addr` in `ADDR_W`: MEM-stage address.
- `pipe_wdata` in `DATA_W`: MEM-stage store data.
- `pipe_rdata` out `DATA_W`: combinational read data to the MEM mux.
- `pipe_stall` out 1: combinational; while 1, the pipeline holds PC, IF/ID, ID/EX and EX/MEM, and inserts a bubble into MEM/WB.
- `ext_req` in 1: external request; `ext_wr`, `ext_addr` and `ext_wdata` must stay stable until `ext_gnt`.
- `ext_wr` in 1: 1 = write, 0 = read.
- `ext_addr` in `ADDR_W`: external address.
- `ext_wdata` in `DATA_W`: external write data.
- `ext_gnt` out 1: combinational; the access completes in this cycle.
- `ext_rdata` out `DATA_W`: registered read data.
- `ext_rvalid` out 1: registered one-cycle pulse.
- `mem_addr` out `ADDR_W`: address to `data_memory`.
- `mem_wdata` out `DATA_W`: write data to `data_memory`.
- `mem_wr` out 1: write enable to `data_memory`.
- `mem_r` out 1: read enable to `data_memory`.
- `mem_rdata` in `DATA_W`: `data_memory` output; combinational read.

## Operation
- `pipe_req = pipe_rd | pipe_wr`.
- Registered state:
  - FSM with states `S_NORMAL` and `S_PIPE_OWED`.
  - 4-bit `starve_cnt`.
- Grant rules in `S_NORMAL`:
  - `pipe_req` set and (`ext_req` clear, or `starve_cnt < STARVE_LIMIT`): pipeline owns the port.
  - `pipe_req` and `ext_req` both set with `starve_cnt == STARVE_LIMIT`: the external requester owns the port. `pipe_stall = 1`, `ext_gnt = 1`, and the next state is `S_PIPE_OWED`.
  - `pipe_req` clear and `ext_req` set: the external requester owns the port, `ext_gnt = 1`, and the state stays `S_NORMAL`.
- Grant rules in `S_PIPE_OWED`:
  - The pipeline owns the port if `pipe_req` is set; otherwise the external requester may be granted.
  - The next state is always `S_NORMAL`.
  - This guarantees that a stalled MEM access completes on the following cycle.
- `starve_cnt` update:
  - Cleared when `ext_req` = 0 or `ext_gnt` = 1.
  - Increments, saturating at `STARVE_LIMIT`, in any cycle where `ext_req` = 1 and the pipeline was granted.
- Memory mux:
  - The owner's address and data drive `mem_*`.
  - `mem_wr` and `mem_r` are asserted only for a granted access; they are 0 when idle.
  - `mem_addr` and `mem_wdata` follow the pipeline inputs when idle.
- `pipe_rdata = mem_rdata` whenever the pipeline owns the port. Its value is don't-care otherwise, but it is driven (no X).
- On an external read grant, `ext_rdata <= mem_rdata` and `ext_rvalid <= 1` for one cycle. An external write produces no `ext_rvalid`.
- Reset (`reset_n = 0` at a clock edge):
  - State `S_NORMAL`, `starve_cnt = 0`, `ext_rvalid = 0`, `ext_rdata = 0`.
  - While reset is low, `pipe_stall`, `ext_gnt`, `mem_wr` and `mem_r` are forced to 0.
  - Reset mid-stall drops the owed turn; the external requester must hold `ext_req` and is re-arbitrated from a zero count.

## Timing
- Pipeline access: 0 added latency; address in, data out in the same cycle, as with the bare `data_memory`.
- External access: `ext_gnt` arrives in the same cycle as the request at the earliest. `ext_rvalid`/`ext_rdata` arrive 1 cycle after the read grant.
- Worst-case external wait with a continuously busy pipeline: `STARVE_LIMIT` cycles, then grant in cycle `STARVE_LIMIT + 1`.
- `pipe_stall` never lasts more than 1 consecutive cycle. Back-to-back stalls are impossible because `S_PIPE_OWED` forces a pipeline grant.
- Simultaneous requests with `pipe_rd` and `pipe_wr` both 0: the external requester gets the port with no stall.

## Configuration
- `DMEM_ARB_FAIRNESS_EN` defined:
  - Counter and `S_PIPE_OWED` logic are present, as described above.
- Not defined:
  - Strict pipeline priority: `starve_cnt` and the FSM are removed.
  - `pipe_stall` is tied to 0.
  - `ext_gnt` is set only in cycles where `pipe_req` = 0.
  - An external request may starve indefinitely.

## Test plan
- Reset: hold `reset_n = 0` with `ext_req = 1` and `pipe_rd = 1` → `ext_gnt`, `pipe_stall`, `mem_wr`, `mem_r` and `ext_rvalid` all 0; `ext_rdata = 0`.
- Pipeline only: `pipe_wr` with addr 0x010, data 0xDEADBEEF, then `pipe_rd` of 0x010 next cycle → `pipe_rdata = 0xDEADBEEF` in the read cycle; `pipe_stall` stays 0.
- Idle-slot external read: preload mem[0x020] = 0x12345678, `pipe_req = 0`, `ext_req` read 0x020 → `ext_gnt = 1` in the same cycle; `ext_rvalid = 1` and `ext_rdata = 0x12345678` the next cycle.
- Starvation with `STARVE_LIMIT = 4`: `pipe_rd` held every cycle and `ext_req` write 0x030 ← 0xA5A5A5A5 → four pipeline grants, then in cycle 5 `pipe_stall = 1`, `ext_gnt = 1` and mem[0x030] = 0xA5A5A5A5. Cycle 6: pipeline granted and `pipe_stall = 0`.
- Reset mid-owed: assert `reset_n = 0` in the cycle after a fairness grant → state returns to `S_NORMAL`; with `ext_req` held, the next external grant comes only after 4 further pipeline wins.
- Macro undefined: the same stimulus as the starvation test for 20 cycles → `ext_gnt` is never asserted and `pipe_stall` is constant 0. Dropping `pipe_rd` for one cycle → `ext_gnt = 1` in that cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and an external requester.
// Define DMEM_ARB_FAIRNESS_EN to add the starvation counter and one-cycle pipeline stall.
module dmem_port_arbiter #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              pipe_rd,
   input  logic              pipe_wr,
   input  logic [ADDR_W-1:0] pipe_addr,
   input  logic [DATA_W-1:0] pipe_wdata,
   output logic [DATA_W-1:0] pipe_rdata,
   output logic              pipe_stall,
   input  logic              ext_req,
   input  logic              ext_wr,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr,
   output logic              mem_r,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic pipe_req;
   logic pipe_gnt;
   logic ext_gnt_raw;
   logic stall_raw;

   assign pipe_req = pipe_rd | pipe_wr;

`ifdef DMEM_ARB_FAIRNESS_EN
   typedef enum logic {S_NORMAL, S_PIPE_OWED} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state, state_nxt;
   logic [3:0] starve_cnt;
   logic       at_limit;

   assign at_limit = (starve_cnt == LIMIT);

   always_ff @(posedge clock) begin
      if (!reset_n) state <= S_NORMAL;
      else          state <= state_nxt;
   end

   // A fairness grant always hands the next cycle back to the stalled MEM access.
   always_comb begin
      state_nxt = S_NORMAL;
      if (state == S_NORMAL && stall_raw) state_nxt = S_PIPE_OWED;
   end

   always_comb begin
      pipe_gnt    = 1'b0;
      ext_gnt_raw = 1'b0;
      stall_raw   = 1'b0;
      case (state)
         S_NORMAL: begin
            if (pipe_req && ext_req && at_limit) begin
               ext_gnt_raw = 1'b1;
               stall_raw   = 1'b1;
            end else if (pipe_req) begin
               pipe_gnt = 1'b1;
            end else begin
               ext_gnt_raw = ext_req;
            end
         end
         default: begin
            if (pipe_req) pipe_gnt = 1'b1;
            else          ext_gnt_raw = ext_req;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n || !ext_req || ext_gnt) starve_cnt <= 4'd0;
      else if (pipe_gnt && !at_limit)      starve_cnt <= starve_cnt + 4'd1;
   end
`else
   assign pipe_gnt    = pipe_req;
   assign ext_gnt_raw = ext_req & ~pipe_req;
   assign stall_raw   = 1'b0;
`endif

   assign pipe_stall = reset_n & stall_raw;
   assign ext_gnt    = reset_n & ext_gnt_raw;

   assign mem_addr   = ext_gnt ? ext_addr  : pipe_addr;
   assign mem_wdata  = ext_gnt ? ext_wdata : pipe_wdata;
   assign mem_wr     = ext_gnt ? ext_wr    : (reset_n & pipe_gnt & pipe_wr);
   assign mem_r      = ext_gnt ? ~ext_wr   : (reset_n & pipe_gnt & pipe_rd);
   assign pipe_rdata = mem_rdata;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ext_rvalid <= 1'b0;
         ext_rdata  <= '0;
      end else begin
         ext_rvalid <= ext_gnt & ~ext_wr;
         if (ext_gnt && !ext_wr) ext_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural data_memory; covers the
// fairness build when DMEM_ARB_FAIRNESS_EN is defined, strict priority otherwise.
module tb_dmem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        pipe_rd, pipe_wr;
   logic [11:0] pipe_addr;
   logic [31:0] pipe_wdata, pipe_rdata;
   logic        pipe_stall;
   logic        ext_req, ext_wr;
   logic [11:0] ext_addr;
   logic [31:0] ext_wdata;
   logic        ext_gnt;
   logic [31:0] ext_rdata;
   logic        ext_rvalid;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr, mem_r;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:4095];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   always_ff @(posedge clock) if (mem_wr) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr),
      .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
      .ext_req(ext_req), .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_r(mem_r),
      .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Next cycle: inputs change at the falling edge, combinational outputs settle 1 time unit later.
   task automatic cyc();
      @(negedge clock);
   endtask

   task automatic pipe(input logic rd, input logic wr, input logic [11:0] a, input logic [31:0] d);
      pipe_rd = rd; pipe_wr = wr; pipe_addr = a; pipe_wdata = d;
   endtask

   task automatic ext(input logic req, input logic wr, input logic [11:0] a, input logic [31:0] d);
      ext_req = req; ext_wr = wr; ext_addr = a; ext_wdata = d;
   endtask

   initial begin
      reset_n = 1'b0;
      pipe(1'b1, 1'b0, 12'h000, 32'h0);
      ext(1'b1, 1'b0, 12'h020, 32'h0);

      // Reset with both requesters active
      cyc(); cyc(); #1;
      chk1("rst_ext_gnt",    ext_gnt,    1'b0);
      chk1("rst_pipe_stall", pipe_stall, 1'b0);
      chk1("rst_mem_wr",     mem_wr,     1'b0);
      chk1("rst_mem_r",      mem_r,      1'b0);
      chk1("rst_ext_rvalid", ext_rvalid, 1'b0);
      chk ("rst_ext_rdata",  ext_rdata,  32'h0);

      // Pipeline-only store then load
      cyc(); reset_n = 1'b1;
      ext(1'b0, 1'b0, 12'h000, 32'h0);
      pipe(1'b0, 1'b1, 12'h010, 32'hDEADBEEF); #1;
      chk1("pw_mem_wr", mem_wr, 1'b1);
      chk1("pw_stall",  pipe_stall, 1'b0);
      cyc(); pipe(1'b1, 1'b0, 12'h010, 32'h0); #1;
      chk ("pr_rdata", pipe_rdata, 32'hDEADBEEF);
      chk1("pr_mem_r", mem_r, 1'b1);
      chk1("pr_stall", pipe_stall, 1'b0);

      // Preload 0x020 through the pipeline, then external read in an idle slot
      cyc(); pipe(1'b0, 1'b1, 12'h020, 32'h12345678);
      cyc(); pipe(1'b0, 1'b0, 12'h000, 32'h0);
      ext(1'b1, 1'b0, 12'h020, 32'h0); #1;
      chk1("er_gnt",    ext_gnt, 1'b1);
      chk1("er_mem_r",  mem_r, 1'b1);
      chk1("er_mem_wr", mem_wr, 1'b0);
      chk ("er_addr",   32'(mem_addr), 32'h020);
      chk1("er_rvalid_early", ext_rvalid, 1'b0);
      cyc(); ext(1'b0, 1'b0, 12'h000, 32'h0); #1;
      chk1("er_rvalid", ext_rvalid, 1'b1);
      chk ("er_rdata",  ext_rdata, 32'h12345678);
      chk1("er_idle_gnt", ext_gnt, 1'b0);
      chk1("er_idle_r",   mem_r, 1'b0);
      cyc(); #1;
      chk1("er_rvalid_pulse", ext_rvalid, 1'b0);

      // External write in an idle slot, read back by the pipeline
      cyc(); ext(1'b1, 1'b1, 12'h040, 32'h0BADF00D); #1;
      chk1("ew_gnt",   ext_gnt, 1'b1);
      chk1("ew_wr",    mem_wr, 1'b1);
      chk1("ew_r",     mem_r, 1'b0);
      chk ("ew_wdata", mem_wdata, 32'h0BADF00D);
      cyc(); ext(1'b0, 1'b0, 12'h000, 32'h0);
      pipe(1'b1, 1'b0, 12'h040, 32'h0); #1;
      chk1("ew_no_rvalid", ext_rvalid, 1'b0);
      chk ("ew_readback",  pipe_rdata, 32'h0BADF00D);

`ifdef DMEM_ARB_FAIRNESS_EN
      // Busy pipeline: four pipeline wins, then a stalled external write
      cyc(); pipe(1'b1, 1'b0, 12'h010, 32'h0);
      ext(1'b1, 1'b1, 12'h030, 32'hA5A5A5A5); #1;
      for (int i = 1; i <= 4; i++) begin
         chk1($sformatf("fw_gnt_c%0d", i),   ext_gnt, 1'b0);
         chk1($sformatf("fw_stall_c%0d", i), pipe_stall, 1'b0);
         chk ($sformatf("fw_rdata_c%0d", i), pipe_rdata, 32'hDEADBEEF);
         cyc(); #1;
      end
      chk1("fw_gnt_c5",   ext_gnt, 1'b1);
      chk1("fw_stall_c5", pipe_stall, 1'b1);
      chk1("fw_wr_c5",    mem_wr, 1'b1);
      chk ("fw_addr_c5",  32'(mem_addr), 32'h030);
      // Owed cycle: pipeline wins even though a new external read waits
      cyc(); ext(1'b1, 1'b0, 12'h030, 32'h0); #1;
      chk1("owed_gnt",   ext_gnt, 1'b0);
      chk1("owed_stall", pipe_stall, 1'b0);
      chk1("owed_r",     mem_r, 1'b1);
      chk ("owed_addr",  32'(mem_addr), 32'h010);
      // Owed cycle counted as win 1; three more, then a stalled read
      for (int i = 2; i <= 4; i++) begin
         cyc(); #1;
         chk1($sformatf("fr_gnt_c%0d", i), ext_gnt, 1'b0);
      end
      cyc(); #1;
      chk1("fr_gnt",   ext_gnt, 1'b1);
      chk1("fr_stall", pipe_stall, 1'b1);
      // Reset in the owed cycle
      cyc(); reset_n = 1'b0; #1;
      chk1("fr_rvalid",    ext_rvalid, 1'b1);
      chk ("fr_rdata",     ext_rdata, 32'hA5A5A5A5);
      chk1("ro_gnt",       ext_gnt, 1'b0);
      chk1("ro_stall",     pipe_stall, 1'b0);
      chk1("ro_mem_r",     mem_r, 1'b0);
      cyc(); reset_n = 1'b1; #1;
      chk1("ro_rvalid_clr", ext_rvalid, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         chk1($sformatf("ro_gnt_c%0d", i),   ext_gnt, 1'b0);
         chk1($sformatf("ro_stall_c%0d", i), pipe_stall, 1'b0);
         cyc(); #1;
      end
      chk1("ro_gnt_c5",   ext_gnt, 1'b1);
      chk1("ro_stall_c5", pipe_stall, 1'b1);
      cyc(); ext(1'b0, 1'b0, 12'h000, 32'h0); #1;
      chk1("ro_stall_c6", pipe_stall, 1'b0);
      chk1("ro_rvalid",   ext_rvalid, 1'b1);
`else
      // Strict priority: a busy pipeline starves the external write
      cyc(); pipe(1'b1, 1'b0, 12'h010, 32'h0);
      ext(1'b1, 1'b1, 12'h030, 32'hA5A5A5A5); #1;
      for (int i = 1; i <= 20; i++) begin
         chk1($sformatf("sp_gnt_c%0d", i),   ext_gnt, 1'b0);
         chk1($sformatf("sp_stall_c%0d", i), pipe_stall, 1'b0);
         cyc(); #1;
      end
      pipe(1'b0, 1'b0, 12'h010, 32'h0); #1;
      chk1("sp_gap_gnt",   ext_gnt, 1'b1);
      chk1("sp_gap_wr",    mem_wr, 1'b1);
      chk1("sp_gap_stall", pipe_stall, 1'b0);
      chk ("sp_gap_addr",  32'(mem_addr), 32'h030);
      cyc(); ext(1'b0, 1'b0, 12'h000, 32'h0);
      pipe(1'b1, 1'b0, 12'h030, 32'h0); #1;
      chk ("sp_readback", pipe_rdata, 32'hA5A5A5A5);
      chk1("sp_no_rvalid", ext_rvalid, 1'b0);
`endif

      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
